// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline hazard/stall signal bundle between ID/EX/MEM stages and the stall unit
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_RegRs;
  logic [4:0]       ID_RegRt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_Branch;
  logic             ID_BranchTaken;
  logic [4:0]       EX_Rd;
  logic [4:0]       MEM_Rd;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic             MEM_RegWrite;
  logic             MEM_MemRead;
  logic             MemStall;
  logic             ClrStats;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken,
    output EX_Rd, MEM_Rd, EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead,
    output MemStall, ClrStats,
    input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, StallCycles
  );

  modport slave (
    input  ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken,
    input  EX_Rd, MEM_Rd, EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead,
    input  MemStall, ClrStats,
    output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, StallCycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch-operand stall detection with bubble insertion and stall statistic
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input logic               Clk,
  input logic               Rst_n,
  hazard_stall_unit_if.slave bus
);
  typedef enum logic {RUN, HOLD} stateE;

  stateE            state;
  stateE            nextState;
  logic [CNT_W-1:0] stallCnt;
  logic [1:0]       need;
  logic             stall;
  logic             exMatch;
  logic             memMatch;
  logic             pcWrite;
  logic             ifidWrite;
  logic             idexBubble;
  logic             ifidFlush;

  // Register 0 is hardwired, so a zero Rd never creates a dependency.
  assign exMatch = bus.EX_RegWrite && (bus.EX_Rd != 5'd0) &&
                   ((bus.ID_UsesRs && (bus.EX_Rd == bus.ID_RegRs)) ||
                    (bus.ID_UsesRt && (bus.EX_Rd == bus.ID_RegRt)));
  assign memMatch = bus.MEM_RegWrite && (bus.MEM_Rd != 5'd0) &&
                    ((bus.ID_UsesRs && (bus.MEM_Rd == bus.ID_RegRs)) ||
                     (bus.ID_UsesRt && (bus.MEM_Rd == bus.ID_RegRt)));

  always_comb begin
    need = 2'd0;
    if (exMatch && bus.EX_MemRead && bus.ID_Branch) begin
      need = 2'd2;
    end else if ((exMatch && bus.EX_MemRead) || (exMatch && bus.ID_Branch) ||
                 (memMatch && bus.MEM_MemRead && bus.ID_Branch)) begin
      need = 2'd1;
    end
  end

  assign stall = (state == HOLD) || (need != 2'd0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    if (bus.MemStall) begin
      // Whole pipeline frozen: a pending HOLD waits rather than being consumed.
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end else begin
      pcWrite    = !stall;
      ifidWrite  = !stall;
      idexBubble = stall;
      ifidFlush  = bus.ID_BranchTaken && !stall;
      if (state == HOLD) begin
        nextState = RUN;
      end else if (need == 2'd2) begin
        nextState = HOLD;
      end else begin
        nextState = RUN;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stallCnt <= '0;
    end else if (bus.ClrStats) begin
      stallCnt <= '0;
    end else if (idexBubble && !(&stallCnt)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign bus.PC_Write    = pcWrite;
  assign bus.IFID_Write  = ifidWrite;
  assign bus.IDEX_Bubble = idexBubble;
  assign bus.IFID_Flush  = ifidFlush;
  assign bus.StallCycles = stallCnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - vector-table and scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;
  localparam int CNT_W = 4;

  typedef struct {
    logic             rstn;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             uRs;
    logic             uRt;
    logic             br;
    logic             tk;
    logic [4:0]       exRd;
    logic             exRw;
    logic             exMr;
    logic [4:0]       memRd;
    logic             memRw;
    logic             memMr;
    logic             mst;
    logic             clr;
    logic             pcw;
    logic             ifw;
    logic             bub;
    logic             fl;
    logic [CNT_W-1:0] cnt;
  } vecT;

  logic Clk;
  logic Rst_n;
  int   nCompared;
  int   nMismatched;
  vecT  expQ[$];
  vecT  tbl[$];

  hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vecT mk(input int rstn, rs, rt, uRs, uRt, br, tk,
                             exRd, exRw, exMr, memRd, memRw, memMr, mst, clr,
                             pcw, ifw, bub, fl, cnt);
    vecT v;
    v.rstn = 1'(rstn);   v.rs = 5'(rs);       v.rt = 5'(rt);
    v.uRs = 1'(uRs);     v.uRt = 1'(uRt);     v.br = 1'(br);     v.tk = 1'(tk);
    v.exRd = 5'(exRd);   v.exRw = 1'(exRw);   v.exMr = 1'(exMr);
    v.memRd = 5'(memRd); v.memRw = 1'(memRw); v.memMr = 1'(memMr);
    v.mst = 1'(mst);     v.clr = 1'(clr);
    v.pcw = 1'(pcw);     v.ifw = 1'(ifw);     v.bub = 1'(bub);   v.fl = 1'(fl);
    v.cnt = CNT_W'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int idx);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  int stepIdx = 0;

  task automatic step(input vecT v);
    vecT e;
    @(negedge Clk);
    Rst_n              = v.rstn;
    bus.ID_RegRs       = v.rs;
    bus.ID_RegRt       = v.rt;
    bus.ID_UsesRs      = v.uRs;
    bus.ID_UsesRt      = v.uRt;
    bus.ID_Branch      = v.br;
    bus.ID_BranchTaken = v.tk;
    bus.EX_Rd          = v.exRd;
    bus.EX_RegWrite    = v.exRw;
    bus.EX_MemRead     = v.exMr;
    bus.MEM_Rd         = v.memRd;
    bus.MEM_RegWrite   = v.memRw;
    bus.MEM_MemRead    = v.memMr;
    bus.MemStall       = v.mst;
    bus.ClrStats       = v.clr;
    expQ.push_back(v);
    #1;
    e = expQ.pop_front();
    chk("PC_Write",    int'(bus.PC_Write),    int'(e.pcw), stepIdx);
    chk("IFID_Write",  int'(bus.IFID_Write),  int'(e.ifw), stepIdx);
    chk("IDEX_Bubble", int'(bus.IDEX_Bubble), int'(e.bub), stepIdx);
    chk("IFID_Flush",  int'(bus.IFID_Flush),  int'(e.fl),  stepIdx);
    chk("StallCycles", int'(bus.StallCycles), int'(e.cnt), stepIdx);
    stepIdx++;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    Rst_n       = 1'b0;
    bus.ID_RegRs = '0; bus.ID_RegRt = '0; bus.ID_UsesRs = 0; bus.ID_UsesRt = 0;
    bus.ID_Branch = 0; bus.ID_BranchTaken = 0; bus.EX_Rd = '0; bus.MEM_Rd = '0;
    bus.EX_RegWrite = 0; bus.EX_MemRead = 0; bus.MEM_RegWrite = 0; bus.MEM_MemRead = 0;
    bus.MemStall = 0; bus.ClrStats = 0;
    repeat (2) @(posedge Clk);

    //              rstn rs rt uRs uRt br tk exRd exRw exMr memRd memRw memMr mst clr pcw ifw bub fl cnt
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8, 0, 1, 1, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8, 0, 1, 1, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(1, 0, 8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3));
    tbl.push_back(mk(1, 3, 0, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(1, 3, 0, 1, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0, 0, 4));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4));
    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4));
    tbl.push_back(mk(1, 0, 6, 0, 1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(1, 0, 6, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Load-to-branch with MemStall held for three cycles inside HOLD
    step(mk(1, 0, 8, 0, 1, 1, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6));
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, 8, 0, 1, 1, 1, 0, 0, 0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 7));
    step(mk(1, 0, 8, 0, 1, 1, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1, 0, 7));
    step(mk(1, 0, 8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 8));

    // Reset asserted while in HOLD
    step(mk(1, 0, 8, 0, 1, 1, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    // Saturation, then ClrStats coincident with a bubble
    for (int i = 0; i < 17; i++)
      step(mk(1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i > 15) ? 15 : i));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 15));
    step(mk(1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 15));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
